sample_framer: RTL and testbench

SAMPLE_FRAMER -- requirements
Module: sample_framer

---
 rtl/sample_framer_if.sv | 28 ++
 rtl/sample_framer.sv | 148 ++++++++++++++
 tb/tb_sample_framer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_framer_if.sv
// sample_framer_if -- sample input and byte output handshake of sample_framer.
// The slave modport is the framer's view; the master modport is the
// environment that drives samples and acts as the UART byte sink.
interface sample_framer_if #(
    parameter int p_width = 16
);
    logic [p_width-1:0] i_data;
    logic               i_strobe;
    logic [7:0]         o_byte;
    logic               o_valid;
    logic               i_ready;

    modport master (
        output i_data,
        output i_strobe,
        output i_ready,
        input  o_byte,
        input  o_valid
    );

    modport slave (
        input  i_data,
        input  i_strobe,
        input  i_ready,
        output o_byte,
        output o_valid
    );
endinterface

// File: rtl/sample_framer.sv
// sample_framer -- buffers decimated audio samples in a FIFO and serialises
// each one as a byte frame (0xA5 sync, high byte, low byte) for a UART.
// Defining SAMPLE_FRAMER_CHECKSUM_EN appends a fourth byte, 0xA5 ^ hi ^ lo.
// Samples arriving while the FIFO is full are dropped and counted (saturating).
module sample_framer #(
    parameter int p_width = 16,
    parameter int p_depth = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    sample_framer_if.slave bus,
    output logic [7:0]     o_drops,
    output logic           o_empty
);
    localparam int         ADDR_W    = $clog2(p_depth);
    localparam int         PTR_W     = ADDR_W + 1;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_HI,
        ST_LO,
        ST_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic [p_width-1:0] hold_q, hold_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [7:0]         byte_q, byte_d;
    logic               valid_q, valid_d;
    logic [7:0]         drops_q, drops_d;
    logic               armed_q, armed_d;

    logic [p_width-1:0] mem [p_depth];

    logic fifo_empty;
    logic fifo_full;
    logic xfer;
    logic frame_done;
    logic pop;
    logic push;

    // The extra pointer bit tells a full FIFO (MSBs differ) from an empty one.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign xfer       = valid_q && bus.i_ready;

    // Next-state logic: frame sequencing, FIFO pop/push and drop counting.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        drops_d    = drops_q;
        armed_d    = 1'b1;
        frame_done = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        byte_d     = 8'h00;

        case (state_q)
            ST_IDLE: pop = !fifo_empty;
            ST_SYNC: if (xfer) state_d = ST_HI;
            ST_HI:   if (xfer) state_d = ST_LO;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
            ST_LO:   if (xfer) state_d = ST_CSUM;
            ST_CSUM: frame_done = xfer;
`else
            ST_LO:   frame_done = xfer;
`endif
            default: state_d = ST_IDLE;
        endcase

        // Back-to-back frames: the last byte's transfer immediately pops the next sample.
        if (frame_done) begin
            if (!fifo_empty) begin
                pop = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (pop) begin
            hold_d   = mem[rd_ptr_q[ADDR_W-1:0]];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            state_d  = ST_SYNC;
        end

        // A full FIFO still accepts a sample when a pop frees a slot in the same cycle.
        if (bus.i_strobe && armed_q) begin
            if (!fifo_full || pop) begin
                push     = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else if (drops_q != 8'hFF) begin
                drops_d = drops_q + 8'd1;
            end
        end

        case (state_d)
            ST_SYNC: byte_d = SYNC_BYTE;
            ST_HI:   byte_d = hold_d[15:8];
            ST_LO:   byte_d = hold_d[7:0];
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
            ST_CSUM: byte_d = SYNC_BYTE ^ hold_d[15:8] ^ hold_d[7:0];
`endif
            default: byte_d = 8'h00;
        endcase
        valid_d = (state_d != ST_IDLE);
    end

    // Sample storage; emptiness is tracked by the pointers, so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= bus.i_data;
        end
    end

    // State, pointers and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            byte_q   <= 8'h00;
            valid_q  <= 1'b0;
            drops_q  <= 8'h00;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            drops_q  <= drops_d;
            armed_q  <= armed_d;
        end
    end

    assign bus.o_byte  = byte_q;
    assign bus.o_valid = valid_q;
    assign o_drops     = drops_q;
    assign o_empty     = fifo_empty && (state_q == ST_IDLE);
endmodule

// File: tb/tb_sample_framer.sv
// tb_sample_framer -- randomized and directed bench for sample_framer.
// A transaction-level model (sample queue, frame byte counter, drop counter)
// pushes expected frame bytes into a scoreboard; a monitor compares them.
module tb_sample_framer;
    localparam int DEPTH = 16;
`ifdef SAMPLE_FRAMER_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] o_drops;
    logic       o_empty;

    sample_framer_if #(.p_width(16)) bus ();

    sample_framer #(.p_width(16), .p_depth(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_drops (o_drops),
        .o_empty (o_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo_m[$];
    logic [7:0]  exp_q[$];
    int          frame_left = 0;
    logic [7:0]  drops_m = 8'h00;
    bit          armed_m = 1'b0;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic strobe, input logic [15:0] data,
                                 input logic ready);
        bus.i_strobe = strobe;
        bus.i_data   = data;
        bus.i_ready  = ready;
        @(posedge clk);
        #1;
        bus.i_strobe = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        bit drained = 1'b0;
        bus.i_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (frame_left == 0 && fifo_m.size() == 0 && exp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("drain_timeout", 16'(drained), 16'd1);
    endtask

    // Reference model: sample queue plus bytes left in the frame being sent.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_m.delete();
            exp_q.delete();
            frame_left = 0;
            drops_m    = 8'h00;
            armed_m    = 1'b0;
        end else begin
            bit          busy;
            bit          xfer;
            bit          take;
            bit          full;
            logic [15:0] s;
            busy = (frame_left > 0);
            xfer = busy && bus.i_ready;
            if (xfer) frame_left--;
            take = (!busy || (xfer && frame_left == 0)) && (fifo_m.size() > 0);
            full = (fifo_m.size() == DEPTH);
            if (take) begin
                s = fifo_m.pop_front();
                exp_q.push_back(8'hA5);
                exp_q.push_back(s[15:8]);
                exp_q.push_back(s[7:0]);
                if (FRAME_LEN == 4) exp_q.push_back(8'hA5 ^ s[15:8] ^ s[7:0]);
                frame_left = FRAME_LEN;
            end
            if (bus.i_strobe && armed_m) begin
                if (!full || take) fifo_m.push_back(bus.i_data);
                else if (drops_m != 8'hFF) drops_m = drops_m + 8'd1;
            end
            armed_m = 1'b1;
        end
    end

    // Monitor: compare outputs mid-cycle; retire a byte when a handshake is due.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("valid", 16'(bus.o_valid), 16'(frame_left > 0));
            checkOutput("drops", 16'(o_drops), 16'(drops_m));
            checkOutput("empty", 16'(o_empty), 16'(fifo_m.size() == 0 && frame_left == 0));
            if (bus.o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL byte_unexpected: got 0x%0h, expected no byte", bus.o_byte);
                end else begin
                    checkOutput("byte", 16'(bus.o_byte), 16'(exp_q[0]));
                    if (bus.i_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        bus.i_strobe = 1'b0;
        bus.i_data   = 16'h0000;
        bus.i_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", 16'(bus.o_valid), 16'd0);
        checkOutput("reset_byte", 16'(bus.o_byte), 16'h00);
        checkOutput("reset_drops", 16'(o_drops), 16'h00);
        checkOutput("reset_empty", 16'(o_empty), 16'd1);
        rst_n = 1'b1;

        $display("[TB] strobe in first cycle after reset release");
        applyStimulus(1'b1, 16'hDEAD, 1'b1);
        repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1);
        checkOutput("ignored_strobe_empty", 16'(o_empty), 16'd1);

        $display("[TB] single frame 0x1234");
        applyStimulus(1'b1, 16'h1234, 1'b1);
        waitDrain(20);
        checkOutput("frame_end_valid", 16'(bus.o_valid), 16'd0);
        checkOutput("frame_end_empty", 16'(o_empty), 16'd1);

        $display("[TB] ready toggling during a frame");
        applyStimulus(1'b1, 16'hA1B2, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        waitDrain(20);

        $display("[TB] overfill with ready low, then write during a pop");
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
        checkOutput("overfill_drops", 16'(o_drops), 16'd1);
        for (int i = 0; i < 20 && frame_left != 1; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
        applyStimulus(1'b1, 16'hC0DE, 1'b1);
        checkOutput("pop_write_drops", 16'(o_drops), 16'd1);
        waitDrain(200);
        checkOutput("after_fill_drops", 16'(o_drops), 16'd1);

        $display("[TB] reset during high byte of 0xBEEF");
        applyStimulus(1'b1, 16'hBEEF, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1);
        bus.i_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midframe_reset_valid", 16'(bus.o_valid), 16'd0);
        checkOutput("midframe_reset_byte", 16'(bus.o_byte), 16'h00);
        checkOutput("midframe_reset_empty", 16'(o_empty), 16'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h5678, 1'b1);
        applyStimulus(1'b1, 16'h5678, 1'b1);
        waitDrain(20);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 4) == 0), 16'($urandom),
                          1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom_range(0, 3) != 0));
        waitDrain(300);

        $display("[TB] drop counter saturation");
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 16'($urandom), 1'b0);
        checkOutput("drops_saturated", 16'(o_drops), 16'h00FF);
        waitDrain(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
